// File: rtl/subleq_pkg.sv
// ---------------------------------------------------------------------------
// subleq_pkg
// Constants shared by control_unit and the SUBLEQ datapath:
//   - address source encodings (adr_reg_sel)
//   - data register encodings  (dat_reg_sel)
//   - PC update encodings      (pc_mod)
//   - default widths and RAM strobe decode helpers
// ---------------------------------------------------------------------------
package subleq_pkg;

    localparam int AW_DEF = 8;
    localparam int DW_DEF = 8;

    // Address source for ram_addr; codes 4-7 also select the PC.
    typedef enum logic [2:0] {
        SEL_PC     = 3'd0,
        SEL_PA     = 3'd1,
        SEL_PB     = 3'd2,
        SEL_PC_PTR = 3'd3
    } adr_sel_e;

    // Read destination / write source; codes 5-7 select nothing.
    // DSEL_OB is the OPD_B latch on reads and the subtract result on writes.
    typedef enum logic [2:0] {
        DSEL_PA = 3'd0,
        DSEL_PB = 3'd1,
        DSEL_PC = 3'd2,
        DSEL_OA = 3'd3,
        DSEL_OB = 3'd4
    } dat_sel_e;

    typedef enum logic [1:0] {
        PC_HOLD = 2'd0,
        PC_INC  = 2'd1,
        PC_BRC  = 2'd2,
        PC_JMP  = 2'd3
    } pc_mod_e;

    // A read capture needs the read strobe without the write strobe: when
    // both strobes are low the cycle is treated as a write only.
    function automatic logic rd_capture(input logic ena, input logic ope_n,
                                        input logic ctl_n, input logic rd_dir);
        return ena & ~ope_n & ctl_n & rd_dir;
    endfunction

    function automatic logic wr_strobe(input logic ena, input logic ctl_n,
                                       input logic rd_dir);
        return ena & ~ctl_n & ~rd_dir;
    endfunction

endpackage

// File: rtl/subleq_datapath_if.sv
// ---------------------------------------------------------------------------
// subleq_datapath_if
// Groups the control strobes from control_unit, the RAM bus and the status
// returned to control_unit.
//   master : control_unit + RAM side (drives strobes and ram_rdata)
//   slave  : subleq_datapath (drives RAM address/data/we and status)
// ---------------------------------------------------------------------------
interface subleq_datapath_if #(
    parameter int AW = 8,
    parameter int DW = 8
);
    // control_unit strobes
    logic [2:0]    adr_reg_sel;
    logic          adr_dir;
    logic [2:0]    dat_reg_sel;
    logic          dat_dir;
    logic          ram_ope;
    logic          ram_ctl;
    logic          ram_ena;
    logic [1:0]    pc_mod;
    // RAM bus
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_rdata;
    logic [DW-1:0] ram_wdata;
    logic          ram_we;
    // status back to control_unit / debug
    logic [DW-1:0] sub_out;
    logic          sub_val;
    logic          halted;
    logic [AW-1:0] pc;

    modport master (
        output adr_reg_sel, adr_dir, dat_reg_sel, dat_dir,
               ram_ope, ram_ctl, ram_ena, pc_mod, ram_rdata,
        input  ram_addr, ram_wdata, ram_we, sub_out, sub_val, halted, pc
    );

    modport slave (
        input  adr_reg_sel, adr_dir, dat_reg_sel, dat_dir,
               ram_ope, ram_ctl, ram_ena, pc_mod, ram_rdata,
        output ram_addr, ram_wdata, ram_we, sub_out, sub_val, halted, pc
    );

endinterface

// File: rtl/subleq_alu.sv
// ---------------------------------------------------------------------------
// subleq_alu
// Registered subtractor for the SUBLEQ datapath.
//   clk, res    : clock, synchronous active-high reset
//   opd_a_i/b_i : operand latches from the datapath
//   opd_cap_i   : an OPD_A or OPD_B capture is strobed this cycle
//   sub_out_o   : registered OPD_B - OPD_A (two's complement wrap)
//   sub_val_o   : sub_out_o reflects the current operand latches
//   leq_o       : sub_out_o <= 0 as a signed value
// ---------------------------------------------------------------------------
module subleq_alu #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          res,
    input  logic [DW-1:0] opd_a_i,
    input  logic [DW-1:0] opd_b_i,
    input  logic          opd_cap_i,
    output logic [DW-1:0] sub_out_o,
    output logic          sub_val_o,
    output logic          leq_o
);

    logic signed [DW-1:0] sub_q, sub_d;
    logic                 val_q, val_d;

    function automatic logic signed [DW-1:0] sub_wrap(input logic signed [DW-1:0] b,
                                                      input logic signed [DW-1:0] a);
        return b - a;
    endfunction

    always_comb begin
        sub_d = sub_wrap($signed(opd_b_i), $signed(opd_a_i));
        // The latched operands change on a capture edge, so the result is
        // only trustworthy one edge after the last capture.
        val_d = ~opd_cap_i;
    end

    // Stage boundary: operand latches -> result register
    always_ff @(posedge clk) begin
        if (res) begin
            sub_q <= '0;
            val_q <= 1'b0;
        end else begin
            sub_q <= sub_d;
            val_q <= val_d;
        end
    end

    assign sub_out_o = sub_q;
    // Masked during a capture cycle so a branch issued alongside an operand
    // load never acts on the previous instruction's result.
    assign sub_val_o = val_q & ~opd_cap_i;
    assign leq_o     = sub_q[DW-1] | ~(|sub_q);

endmodule

// File: rtl/subleq_datapath.sv
// ---------------------------------------------------------------------------
// subleq_datapath
// Datapath stage of the SUBLEQ machine: PC, operand pointers (A, B, C),
// operand values and subtract result; executes mem[B] -= mem[A] and
// branches to C when the result is <= 0. A taken branch to HALT_ADDR halts.
//   clk : system clock, rising edge
//   res : synchronous active-high reset, priority over every strobe
//   bus : subleq_datapath_if.slave -- control strobes in, RAM address /
//         write data / write enable out, sub_out/sub_val/halted/pc out
// ---------------------------------------------------------------------------
module subleq_datapath
    import subleq_pkg::*;
#(
    parameter int            AW        = AW_DEF,
    parameter int            DW        = DW_DEF,
    parameter logic [AW-1:0] RESET_PC  = '0,
    parameter logic [AW-1:0] HALT_ADDR = {AW{1'b1}}
) (
    input  logic               clk,
    input  logic               res,
    subleq_datapath_if.slave   bus
);

    logic [AW-1:0] pc_q,    pc_d;
    logic [AW-1:0] ptr_a_q, ptr_a_d;
    logic [AW-1:0] ptr_b_q, ptr_b_d;
    logic [AW-1:0] ptr_c_q, ptr_c_d;
    logic [DW-1:0] opd_a_q, opd_a_d;
    logic [DW-1:0] opd_b_q, opd_b_d;
    logic          halted_q, halted_d;

    logic          cap;
    logic          wr;
    logic          opd_cap;
    logic          take;
    logic [DW-1:0] sub_out;
    logic          sub_val;
    logic          leq;

    assign cap = rd_capture(bus.ram_ena, bus.ram_ope, bus.ram_ctl, bus.dat_dir);
    assign wr  = wr_strobe(bus.ram_ena, bus.ram_ctl, bus.dat_dir);
    assign opd_cap = cap & ((bus.dat_reg_sel == DSEL_OA) || (bus.dat_reg_sel == DSEL_OB));

    subleq_alu #(.DW(DW)) u_alu (
        .clk       (clk),
        .res       (res),
        .opd_a_i   (opd_a_q),
        .opd_b_i   (opd_b_q),
        .opd_cap_i (opd_cap),
        .sub_out_o (sub_out),
        .sub_val_o (sub_val),
        .leq_o     (leq)
    );

    // Register capture from RAM read data
    always_comb begin
        ptr_a_d = ptr_a_q;
        ptr_b_d = ptr_b_q;
        ptr_c_d = ptr_c_q;
        opd_a_d = opd_a_q;
        opd_b_d = opd_b_q;
        if (cap) begin
            case (bus.dat_reg_sel)
                DSEL_PA: ptr_a_d = bus.ram_rdata;
                DSEL_PB: ptr_b_d = bus.ram_rdata;
                DSEL_PC: ptr_c_d = bus.ram_rdata;
                DSEL_OA: opd_a_d = bus.ram_rdata;
                DSEL_OB: opd_b_d = bus.ram_rdata;
                default: ;
            endcase
        end
    end

    // PC update and halt detection. Branches read ptr_c_q, so a PTR_C
    // capture in the same cycle does not affect the target.
    always_comb begin
        pc_d     = pc_q;
        halted_d = halted_q;
        take     = 1'b0;
        if (!halted_q) begin
            case (bus.pc_mod)
                PC_INC:  pc_d = pc_q + 1'b1;
                PC_BRC:  take = sub_val & leq;
                PC_JMP:  take = 1'b1;
                default: ;
            endcase
            if (take) begin
                pc_d = ptr_c_q;
                if (ptr_c_q == HALT_ADDR) begin
                    halted_d = 1'b1;
                end
            end
        end
    end

    // Stage boundary: strobes and read data -> architectural registers
    always_ff @(posedge clk) begin
        if (res) begin
            pc_q     <= RESET_PC;
            ptr_a_q  <= '0;
            ptr_b_q  <= '0;
            ptr_c_q  <= '0;
            opd_a_q  <= '0;
            opd_b_q  <= '0;
            halted_q <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            ptr_a_q  <= ptr_a_d;
            ptr_b_q  <= ptr_b_d;
            ptr_c_q  <= ptr_c_d;
            opd_a_q  <= opd_a_d;
            opd_b_q  <= opd_b_d;
            halted_q <= halted_d;
        end
    end

    // Address mux; adr_dir=1 releases the bus by forcing address 0.
    always_comb begin
        bus.ram_addr = '0;
        if (!bus.adr_dir) begin
            case (bus.adr_reg_sel)
                SEL_PA:     bus.ram_addr = ptr_a_q;
                SEL_PB:     bus.ram_addr = ptr_b_q;
                SEL_PC_PTR: bus.ram_addr = ptr_c_q;
                default:    bus.ram_addr = pc_q;
            endcase
        end
    end

    // Write data mux; the OPD_B code writes back the subtract result.
    always_comb begin
        case (bus.dat_reg_sel)
            DSEL_PA: bus.ram_wdata = ptr_a_q;
            DSEL_PB: bus.ram_wdata = ptr_b_q;
            DSEL_PC: bus.ram_wdata = ptr_c_q;
            DSEL_OA: bus.ram_wdata = opd_a_q;
            DSEL_OB: bus.ram_wdata = sub_out;
            default: bus.ram_wdata = '0;
        endcase
    end

    // Reset suppresses a write strobed in the same cycle.
    assign bus.ram_we  = wr & ~halted_q & ~res;
    assign bus.sub_out = sub_out;
    assign bus.sub_val = sub_val;
    assign bus.halted  = halted_q;
    assign bus.pc      = pc_q;

endmodule
